regfile_wr_arbiter: RTL and testbench

- Shares the register file's single write port (load, dest, in) between NUM_REQ independent requesters using registered round-robin arbitration.
- Also contains a clear sequencer that zeroes R0..R7 on command, one register per cycle.
- Sits between the execution/memory/writeback sources and the 8x16 register file.
- Drives the register file's write port directly; does not touch the read ports.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/regfile_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types.
package regfile_pkg;

   localparam int unsigned REG_W      = 16;
   localparam int unsigned REG_ADDR_W = 3;
   localparam int unsigned NUM_REGS   = 8;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [REG_W-1:0]      reg_data_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } wr_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first set request at or after ptr, wrapping at N.
module rr_pick
   import regfile_pkg::*;
#(
   parameter int unsigned N     = 3,
   parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic             valid
);

   // Scan distances from ptr in increasing order; first requester found wins.
   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      for (int d = 0; d < int'(N); d++) begin
         for (int j = 0; j < int'(N); j++) begin
            if (!valid && req[j] && ((j - int'(ptr) + int'(N)) % int'(N)) == d) begin
               gnt[j] = 1'b1;
               valid  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file write port, with a sequential clear sweep.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned DATA_W  = REG_W,
   parameter int unsigned ADDR_W  = REG_ADDR_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   input  logic                      clear_req,
   output logic                      clear_done,
   output logic                      busy,
   output logic                      rf_load,
   output logic [ADDR_W-1:0]         rf_dest,
   output logic [DATA_W-1:0]         rf_in
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   wr_arb_state_t       state, state_nxt;
   logic [PTR_W-1:0]    rr_ptr, rr_ptr_d;
   logic [ADDR_W-1:0]   clr_cnt, clr_cnt_d;
   logic                clr_last;

   logic [NUM_REQ-1:0]  eff_req;
   logic [NUM_REQ-1:0]  pick_oh;
   logic                pick_vld;
   logic [PTR_W-1:0]    win_idx;
   logic [PTR_W-1:0]    win_ptr_nxt;
   logic [ADDR_W-1:0]   win_dest;
   logic [DATA_W-1:0]   win_data;

   logic [NUM_REQ-1:0]  gnt_d;
   logic                rf_load_d;
   logic [ADDR_W-1:0]   rf_dest_d;
   logic [DATA_W-1:0]   rf_in_d;
   logic                clear_done_d;
   logic                busy_d;

   // A requester is masked during its own grant cycle so a late req drop cannot double-write.
   assign eff_req  = req & ~gnt;
   assign clr_last = &clr_cnt;

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (eff_req),
      .ptr   (rr_ptr),
      .gnt   (pick_oh),
      .valid (pick_vld)
   );

   // Encode the winner and select its destination/data slices.
   always_comb begin
      win_idx  = '0;
      win_dest = '0;
      win_data = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (pick_oh[i]) begin
            win_idx  = win_idx | PTR_W'(i);
            win_dest = req_dest[i*ADDR_W +: ADDR_W];
            win_data = req_data[i*DATA_W +: DATA_W];
         end
      end
      win_ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         clr_cnt    <= '0;
         gnt        <= '0;
         rf_load    <= 1'b0;
         rf_dest    <= '0;
         rf_in      <= '0;
         clear_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_d;
         clr_cnt    <= clr_cnt_d;
         gnt        <= gnt_d;
         rf_load    <= rf_load_d;
         rf_dest    <= rf_dest_d;
         rf_in      <= rf_in_d;
         clear_done <= clear_done_d;
         busy       <= busy_d;
      end
   end

   // Next-state: clear command wins over pending requests; sweep ends after the last index.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clear_req) state_nxt = CLEAR;
         CLEAR:   if (clr_last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for the registered outputs, pointer and clear counter.
   always_comb begin
      gnt_d        = '0;
      rf_load_d    = 1'b0;
      rf_dest_d    = rf_dest;
      rf_in_d      = rf_in;
      clear_done_d = 1'b0;
      busy_d       = (state_nxt == CLEAR);
      rr_ptr_d     = rr_ptr;
      clr_cnt_d    = clr_cnt;
      case (state)
         IDLE: begin
            if (!clear_req && pick_vld) begin
               gnt_d     = pick_oh;
               rf_load_d = 1'b1;
               rf_dest_d = win_dest;
               rf_in_d   = win_data;
               rr_ptr_d  = win_ptr_nxt;
            end
         end
         CLEAR: begin
            rf_load_d    = 1'b1;
            rf_dest_d    = clr_cnt;
            rf_in_d      = '0;
            clr_cnt_d    = clr_cnt + ADDR_W'(1);
            clear_done_d = clr_last;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: vector table, clear corner sequences, random vs model.
module tb_regfile_wr_arbiter;

   localparam int N     = 3;
   localparam int AW    = 3;
   localparam int DW    = 16;
   localparam int NREGS = 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      req;
   logic [N*AW-1:0]   req_dest;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      gnt;
   logic              clear_req;
   logic              clear_done;
   logic              busy;
   logic              rf_load;
   logic [AW-1:0]     rf_dest;
   logic [DW-1:0]     rf_in;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(
      .NUM_REQ (N),
      .DATA_W  (DW),
      .ADDR_W  (AW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .req_dest   (req_dest),
      .req_data   (req_data),
      .gnt        (gnt),
      .clear_req  (clear_req),
      .clear_done (clear_done),
      .busy       (busy),
      .rf_load    (rf_load),
      .rf_dest    (rf_dest),
      .rf_in      (rf_in)
   );

   // Reference model: abstract arbiter/clear behaviour tracked with plain integers.
   bit           m_clearing = 1'b0;
   int           m_step     = 0;
   int           m_ptr      = 0;
   logic [N-1:0] m_gnt      = '0;
   logic         m_load     = 1'b0;
   logic [AW-1:0] m_dest    = '0;
   logic [DW-1:0] m_data    = '0;
   logic         m_busy     = 1'b0;
   logic         m_done     = 1'b0;

   task automatic model_step();
      logic [N-1:0] pend;
      int           win;
      if (!reset_n) begin
         m_clearing = 1'b0; m_step = 0; m_ptr = 0; m_gnt = '0; m_load = 1'b0;
         m_dest = '0; m_data = '0; m_busy = 1'b0; m_done = 1'b0;
      end else if (m_clearing) begin
         m_gnt  = '0;
         m_load = 1'b1;
         m_dest = AW'(m_step);
         m_data = '0;
         if (m_step == NREGS - 1) begin
            m_clearing = 1'b0; m_step = 0; m_done = 1'b1; m_busy = 1'b0;
         end else begin
            m_step++; m_done = 1'b0; m_busy = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (clear_req) begin
            m_clearing = 1'b1; m_busy = 1'b1; m_gnt = '0; m_load = 1'b0;
         end else begin
            m_busy = 1'b0;
            pend   = req & ~m_gnt;
            win    = -1;
            for (int off = 0; off < N; off++)
               if (win < 0 && pend[(m_ptr + off) % N]) win = (m_ptr + off) % N;
            if (win >= 0) begin
               m_gnt  = N'(1 << win);
               m_load = 1'b1;
               m_dest = req_dest[win*AW +: AW];
               m_data = req_data[win*DW +: DW];
               m_ptr  = (win + 1) % N;
            end else begin
               m_gnt  = '0;
               m_load = 1'b0;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: advance the model on the current inputs, then compare 1 time unit after the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("m_gnt",  32'(gnt),        32'(m_gnt));
      check("m_load", 32'(rf_load),    32'(m_load));
      check("m_dest", 32'(rf_dest),    32'(m_dest));
      check("m_data", 32'(rf_in),      32'(m_data));
      check("m_busy", 32'(busy),       32'(m_busy));
      check("m_done", 32'(clear_done), 32'(m_done));
   endtask

   typedef struct {
      logic          rst_n;
      logic [N-1:0]  rq;
      logic          clr;
      logic [N-1:0]  e_gnt;
      logic          e_load;
      logic [AW-1:0] e_dest;
      logic [DW-1:0] e_data;
   } vec_t;

   function automatic vec_t mk(logic r, logic [N-1:0] q, logic c, logic [N-1:0] g,
                               logic l, logic [AW-1:0] d, logic [DW-1:0] x);
      vec_t v;
      v.rst_n = r; v.rq = q; v.clr = c; v.e_gnt = g; v.e_load = l; v.e_dest = d; v.e_data = x;
      return v;
   endfunction

   vec_t vecs[17];

   initial begin
      int wr_cnt;
      int done_cnt;
      int gnt_cnt;

      reset_n   = 1'b0;
      req       = '0;
      clear_req = 1'b0;
      req_dest  = {3'd6, 3'd5, 3'd2};
      req_data  = {16'h2222, 16'hBEEF, 16'h1111};

      // Single request, round-robin sweep from reset, single requester held.
      vecs[0]  = mk(1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 3'd0, 16'h0000);
      vecs[1]  = mk(1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 3'd5, 16'hBEEF);
      vecs[2]  = mk(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'd5, 16'hBEEF);
      vecs[3]  = mk(1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 3'd0, 16'h0000);
      vecs[4]  = mk(1'b1, 3'b111, 1'b0, 3'b001, 1'b1, 3'd2, 16'h1111);
      vecs[5]  = mk(1'b1, 3'b111, 1'b0, 3'b010, 1'b1, 3'd5, 16'hBEEF);
      vecs[6]  = mk(1'b1, 3'b111, 1'b0, 3'b100, 1'b1, 3'd6, 16'h2222);
      vecs[7]  = mk(1'b1, 3'b111, 1'b0, 3'b001, 1'b1, 3'd2, 16'h1111);
      vecs[8]  = mk(1'b1, 3'b111, 1'b0, 3'b010, 1'b1, 3'd5, 16'hBEEF);
      vecs[9]  = mk(1'b1, 3'b111, 1'b0, 3'b100, 1'b1, 3'd6, 16'h2222);
      vecs[10] = mk(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'd6, 16'h2222);
      vecs[11] = mk(1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 3'd2, 16'h1111);
      vecs[12] = mk(1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 3'd2, 16'h1111);
      vecs[13] = mk(1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 3'd2, 16'h1111);
      vecs[14] = mk(1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 3'd2, 16'h1111);
      vecs[15] = mk(1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 3'd2, 16'h1111);
      vecs[16] = mk(1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 3'd2, 16'h1111);

      for (int i = 0; i < 17; i++) begin
         reset_n   = vecs[i].rst_n;
         req       = vecs[i].rq;
         clear_req = vecs[i].clr;
         tick();
         check($sformatf("v%0d_gnt", i),  32'(gnt),        32'(vecs[i].e_gnt));
         check($sformatf("v%0d_load", i), 32'(rf_load),    32'(vecs[i].e_load));
         check($sformatf("v%0d_dest", i), 32'(rf_dest),    32'(vecs[i].e_dest));
         check($sformatf("v%0d_data", i), 32'(rf_in),      32'(vecs[i].e_data));
         check($sformatf("v%0d_busy", i), 32'(busy),       32'(1'b0));
         check($sformatf("v%0d_done", i), 32'(clear_done), 32'(1'b0));
      end

      // Clear and a pending request in the same cycle: clear wins, request served afterwards.
      req       = 3'b001;
      clear_req = 1'b1;
      tick();
      check("clrA_enter_busy", 32'(busy), 32'(1'b1));
      check("clrA_enter_gnt",  32'(gnt),  32'(0));
      clear_req = 1'b0;
      done_cnt  = 0;
      gnt_cnt   = 0;
      for (int c = 0; c < NREGS; c++) begin
         tick();
         check($sformatf("clrA_load%0d", c), 32'(rf_load), 32'(1'b1));
         check($sformatf("clrA_dest%0d", c), 32'(rf_dest), 32'(c));
         check($sformatf("clrA_data%0d", c), 32'(rf_in),   32'(0));
         if (gnt != '0) gnt_cnt++;
         done_cnt += int'(clear_done);
      end
      check("clrA_done_cnt", 32'(done_cnt), 32'(1));
      check("clrA_gnt_cnt",  32'(gnt_cnt),  32'(0));
      check("clrA_busy_end", 32'(busy),     32'(1'b0));
      tick();
      check("clrA_post_gnt",  32'(gnt),     32'(3'b001));
      check("clrA_post_dest", 32'(rf_dest), 32'(3'd2));
      check("clrA_post_data", 32'(rf_in),   32'(16'h1111));
      req = '0;
      tick();

      // Clear re-pulsed mid-sweep: ignored.
      clear_req = 1'b1;
      tick();
      wr_cnt   = 0;
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         clear_req = (c == 2);
         tick();
         wr_cnt   += int'(rf_load);
         done_cnt += int'(clear_done);
      end
      clear_req = 1'b0;
      check("clrB_writes",   32'(wr_cnt),   32'(8));
      check("clrB_done_cnt", 32'(done_cnt), 32'(1));

      // Reset mid-sweep abandons the clear and returns the pointer to 0.
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      reset_n = 1'b0;
      tick();
      check("rstC_busy", 32'(busy),       32'(1'b0));
      check("rstC_load", 32'(rf_load),    32'(1'b0));
      check("rstC_gnt",  32'(gnt),        32'(0));
      check("rstC_done", 32'(clear_done), 32'(1'b0));
      reset_n = 1'b1;
      req     = 3'b100;
      tick();
      check("rstC_gnt2",  32'(gnt),     32'(3'b100));
      check("rstC_dest2", 32'(rf_dest), 32'(3'd6));
      req = '0;
      tick();

      // Randomized traffic with occasional clears and resets.
      for (int n = 0; n < 400; n++) begin
         reset_n   = ($urandom_range(0, 99) != 0);
         clear_req = ($urandom_range(0, 29) == 0);
         req       = N'($urandom);
         if ($urandom_range(0, 3) == 0) req_dest = (N*AW)'($urandom);
         if ($urandom_range(0, 3) == 0) req_data = {16'($urandom), 16'($urandom), 16'($urandom)};
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
